la_iobank_cfgseq: RTL and testbench
===================================

Name: la_iobank_cfgseq

Overview:
Configuration and power-sequencing controller for a bank of N bidirectional sky130 GPIO pads, each built on the gpiov2 wrapped cell.
- Drives each pad's 16-bit generic cfg bus.
- Holds a per-channel shadow config register.
- Runs the power-up / hold sequence on ENABLE_H (cfg bit 1) and HLD_H_N (cfg bit 0) that was previously tied off statically.
- Sits in the core power domain, next to the pad ring. Fed by a register-bus bridge.

Parameters:
N, 8, number of pad channels (1..64)
CFGW, 16, cfg width per pad (fixed bit map; must be 16)
RSTCFG, 16'hC000, shadow reset value (DM=3'b110, all other bits 0)
PWRUP_CYC, 64, cycles in PWRUP with ENABLE_H=0 (>=1)
SETTLE_CYC, 16, cycles in ARM with ENABLE_H=1, HLD_H_N=0 (>=1)
AW, $clog2(N) (min 1), channel address width (localparam)

Ports:
clk  input  1  clock
nreset  input  1  async active-low reset
en  input  1  bank enable; low forces OFF
sleep_req  input  1  level request to freeze pads (HOLD)
cfg_valid  input  1  write request
cfg_ready  output  1  write accepted when valid&ready
cfg_addr  input  AW  target channel
cfg_wdata  input  CFGW  new shadow value (bits 1:0 ignored)
cfg_bcast  input  1  broadcast write (only with macro)
cfg_err  output  1  one-cycle pulse: accepted write with addr>=N
state  output  3  FSM state code
pwr_good  output  1  state==RUN
sleep_ack  output  1  state==HOLD
cfg  output  N*CFGW  per-pad cfg, channel i at [i*CFGW +: CFGW]

Behaviour:
- One clock. Reset is asynchronous, active-low (nreset). On reset:
  - all shadows = RSTCFG
  - FSM = OFF; counter = 0
  - cfg_err = 0
  - cfg bits[1:0] = 0 for all channels (pads hi-z, held)
- cfg[i] = {shadow[i][15:2], hld_h_n, enable_h}. Outputs are registered or decoded from registers only; no input→output combinational path.
- FSM codes and behaviour:
  - OFF (0): enable_h=0, hld_h_n=0.
  - PWRUP (1): enable_h=0, hld_h_n=0. Stays exactly PWRUP_CYC cycles, then → ARM.
  - ARM (2): enable_h=1, hld_h_n=0. Stays exactly SETTLE_CYC cycles, then → RUN.
  - RUN (3): enable_h=1, hld_h_n=1.
  - HOLD (4): enable_h=1, hld_h_n=0.
- Transitions:
  - OFF→PWRUP on the first edge with en=1.
  - RUN→HOLD on sleep_req=1.
  - HOLD→ARM on sleep_req=0. The pad re-settles before hold is released, so HOLD never goes directly to RUN.
- en=0 in any state → OFF next edge, counter cleared. This has priority over sleep_req and counter expiry.
- Counter: the down-counter is loaded on entry to PWRUP/ARM. The state advances on the edge where the count reaches 0.
- cfg_ready = 1 in OFF, RUN and HOLD; 0 in PWRUP and ARM.
- Accepted write:
  - updates shadow[cfg_addr][15:2] on that edge; new value visible on cfg after the same edge (latency 1).
  - bits[1:0] of cfg_wdata are ignored.
- addr>=N: write accepted, no shadow changes, cfg_err=1 for one cycle.
- Writes in HOLD update the shadow; the pad ignores them until hld_h_n rises.
- Write and sleep_req in the same RUN cycle: the write completes and the state moves to HOLD.
- Write and en falling in the same cycle: the write completes (ready was 1) and the state moves to OFF.
- Shadows keep their values through OFF; only nreset restores RSTCFG.
- nreset asserted mid-sequence: immediate return to the reset values above.

Optional Feature:
LA_IOBANK_BCAST_EN
- Defined: an accepted write with cfg_bcast=1 updates all N shadows[15:2] in one edge, ignoring cfg_addr; cfg_err stays 0.
- Undefined: cfg_bcast is ignored; behaviour is the addressed write only.

Decomposition:
- Package la_iobank_pkg:
  - state encoding constants OFF/PWRUP/ARM/RUN/HOLD
  - cfg bit-index constants (HLD_H_N=0, ENABLE_H=1, ENABLE_INP_H=2, SLOW=8, DM_LSB=13, DM_MSB=15)
  - default RSTCFG
- One sub-module, la_iobank_timer: loadable down-counter with zero flag, width $clog2(max(PWRUP_CYC,SETTLE_CYC))+1.

Test Plan:
1. Reset then en=1 with N=4, PWRUP_CYC=4, SETTLE_CYC=2:
   - enable_h rises exactly 5 edges after en is sampled, hld_h_n 2 edges later.
   - pwr_good=1; all cfg = 16'hC003.
2. RUN, write addr=2, data=16'h0104 → cfg[2] = 16'h0107 next edge; other channels unchanged.
3. Write addr=5 with N=4 → cfg_err pulses one cycle; all shadows unchanged.
4. In RUN:
   - sleep_req=1 → state=HOLD, hld_h_n=0, sleep_ack=1.
   - write ch0=16'h4000 during HOLD.
   - release → ARM for 2 cycles, then RUN with cfg[0] = 16'h4003.
5. en dropped mid-PWRUP and again mid-ARM → OFF next edge, cfg[1:0] = 0, cfg_ready=1.
6. nreset pulse while in RUN after writes → cfg bits[1:0] = 0 and shadows = 16'hC000 asynchronously. With LA_IOBANK_BCAST_EN, a bcast write of 16'h2000 sets all N channels to 16'h2003.

Source files
------------

// File: rtl/la_iobank_pkg.sv
// Shared definitions for the GPIO bank configuration sequencer:
// FSM state encoding, pad cfg bit indices and the default shadow value.
package la_iobank_pkg;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_PWRUP = 3'd1,
        ST_ARM   = 3'd2,
        ST_RUN   = 3'd3,
        ST_HOLD  = 3'd4
    } state_e;

    // Bit positions inside the 16-bit gpiov2 generic cfg bus
    localparam int unsigned CFG_HLD_H_N      = 0;
    localparam int unsigned CFG_ENABLE_H     = 1;
    localparam int unsigned CFG_ENABLE_INP_H = 2;
    localparam int unsigned CFG_SLOW         = 8;
    localparam int unsigned CFG_DM_LSB       = 13;
    localparam int unsigned CFG_DM_MSB       = 15;

    // DM = 3'b110, everything else cleared
    localparam logic [15:0] LA_RSTCFG = 16'hC000;

endpackage

// File: rtl/la_iobank_timer.sv
// Loadable down-counter with a zero flag, used to time the PWRUP and
// ARM phases of the pad power sequence.
module la_iobank_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear wins over load, load wins over decrement; saturate at 0
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/la_iobank_cfgseq.sv
// Configuration and power-sequencing controller for a bank of N sky130
// gpiov2 pads. Holds per-channel shadow cfg registers and drives the
// ENABLE_H / HLD_H_N power-up and hold sequence on every pad.
// Optional feature macro: LA_IOBANK_BCAST_EN (broadcast shadow writes).
module la_iobank_cfgseq
    import la_iobank_pkg::*;
#(
    parameter int unsigned N          = 8,
    parameter int unsigned CFGW       = 16,
    parameter logic [15:0] RSTCFG     = LA_RSTCFG,
    parameter int unsigned PWRUP_CYC  = 64,
    parameter int unsigned SETTLE_CYC = 16,
    localparam int unsigned AW        = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              en,
    input  logic              sleep_req,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [CFGW-1:0]   cfg_wdata,
    input  logic              cfg_bcast,
    output logic              cfg_err,
    output logic [2:0]        state,
    output logic              pwr_good,
    output logic              sleep_ack,
    output logic [N*CFGW-1:0] cfg
);

    localparam int unsigned MAXCYC = (PWRUP_CYC > SETTLE_CYC) ? PWRUP_CYC : SETTLE_CYC;
    localparam int unsigned CNTW   = $clog2(MAXCYC) + 1;
    // Loading CYC-1 makes the phase last exactly CYC cycles: it advances on
    // the edge where the counter is already zero.
    localparam logic [CNTW-1:0] PWRUP_LD  = CNTW'(PWRUP_CYC - 1);
    localparam logic [CNTW-1:0] SETTLE_LD = CNTW'(SETTLE_CYC - 1);

    state_e            state_q, state_d;
    logic              cnt_clr, cnt_load, cnt_dec, cnt_zero;
    logic [CNTW-1:0]   cnt_ld_val;
    logic [CFGW-1:2]   shadow_q [N];
    logic              err_q, err_d;
    logic              enable_h, hld_h_n;
    logic              wr_acc, addr_oor, wr_bcast;
    logic              unused_in;

    la_iobank_timer #(
        .W (CNTW)
    ) u_timer (
        .clk_i      (clk),
        .rst_ni     (nreset),
        .clr_i      (cnt_clr),
        .load_i     (cnt_load),
        .load_val_i (cnt_ld_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

`ifdef LA_IOBANK_BCAST_EN
    assign wr_bcast  = cfg_bcast;
    assign unused_in = ^cfg_wdata[1:0];
`else
    assign wr_bcast  = 1'b0;
    assign unused_in = ^{cfg_bcast, cfg_wdata[1:0]};
`endif

    assign wr_acc   = cfg_valid & cfg_ready;
    assign addr_oor = (32'(cfg_addr) >= N);
    assign err_d    = wr_acc & ~wr_bcast & addr_oor;

    // FSM state register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and timer control; en low overrides everything else
    always_comb begin
        state_d    = state_q;
        cnt_clr    = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        cnt_ld_val = '0;
        if (!en) begin
            state_d = ST_OFF;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d    = ST_PWRUP;
                    cnt_load   = 1'b1;
                    cnt_ld_val = PWRUP_LD;
                end
                ST_PWRUP: begin
                    if (cnt_zero) begin
                        state_d    = ST_ARM;
                        cnt_load   = 1'b1;
                        cnt_ld_val = SETTLE_LD;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_ARM: begin
                    if (cnt_zero) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (sleep_req) begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Re-settle through ARM before the hold is released
                    if (!sleep_req) begin
                        state_d    = ST_ARM;
                        cnt_load   = 1'b1;
                        cnt_ld_val = SETTLE_LD;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    // Pad control and handshake outputs decoded from the state register
    always_comb begin
        enable_h  = 1'b0;
        hld_h_n   = 1'b0;
        cfg_ready = 1'b0;
        pwr_good  = 1'b0;
        sleep_ack = 1'b0;
        case (state_q)
            ST_OFF: begin
                cfg_ready = 1'b1;
            end
            ST_ARM: begin
                enable_h = 1'b1;
            end
            ST_RUN: begin
                enable_h  = 1'b1;
                hld_h_n   = 1'b1;
                cfg_ready = 1'b1;
                pwr_good  = 1'b1;
            end
            ST_HOLD: begin
                enable_h  = 1'b1;
                cfg_ready = 1'b1;
                sleep_ack = 1'b1;
            end
            default: begin
                enable_h = 1'b0;
            end
        endcase
    end

    // Shadow registers: addressed (or broadcast) write of bits [15:2]
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int unsigned i = 0; i < N; i++) begin
                shadow_q[i] <= RSTCFG[CFGW-1:2];
            end
        end else if (wr_acc) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (wr_bcast || (cfg_addr == AW'(i))) begin
                    shadow_q[i] <= cfg_wdata[CFGW-1:2];
                end
            end
        end
    end

    // One-cycle error pulse for an accepted write to a missing channel
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    // Per-pad cfg bus: shadow upper bits plus sequencer-owned power bits
    always_comb begin
        cfg = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cfg[i*CFGW +: CFGW]           = {shadow_q[i], 2'b00};
            cfg[i*CFGW + CFG_ENABLE_H]    = enable_h;
            cfg[i*CFGW + CFG_HLD_H_N]     = hld_h_n;
        end
    end

    assign cfg_err = err_q;
    assign state   = state_q;

endmodule

// File: tb/tb_la_iobank_cfgseq.sv
// Scoreboard bench for la_iobank_cfgseq (N=5, PWRUP_CYC=4, SETTLE_CYC=2).
module tb_la_iobank_cfgseq;

    localparam int unsigned N    = 5;
    localparam int unsigned CFGW = 16;
    localparam int unsigned AW   = 3;

    localparam int K_STATE = 0;
    localparam int K_CFG   = 1;
    localparam int K_ERR   = 2;
    localparam int K_READY = 3;
    localparam int K_PGOOD = 4;
    localparam int K_SACK  = 5;

    logic              clk = 1'b0;
    logic              nreset, en, sleep_req, cfg_valid, cfg_bcast;
    logic [AW-1:0]     cfg_addr;
    logic [CFGW-1:0]   cfg_wdata;
    logic              cfg_ready, cfg_err, pwr_good, sleep_ack;
    logic [2:0]        state;
    logic [N*CFGW-1:0] cfg;

    typedef struct {
        string       name;
        int          kind;
        int          ch;
        logic [15:0] exp;
    } chk_t;

    chk_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] sh [N];

    la_iobank_cfgseq #(
        .N          (N),
        .CFGW       (CFGW),
        .RSTCFG     (16'hC000),
        .PWRUP_CYC  (4),
        .SETTLE_CYC (2)
    ) dut (
        .clk       (clk),
        .nreset    (nreset),
        .en        (en),
        .sleep_req (sleep_req),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_bcast (cfg_bcast),
        .cfg_err   (cfg_err),
        .state     (state),
        .pwr_good  (pwr_good),
        .sleep_ack (sleep_ack),
        .cfg       (cfg)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] actual(int kind, int ch);
        case (kind)
            K_STATE: return {13'd0, state};
            K_CFG:   return cfg[ch*CFGW +: CFGW];
            K_ERR:   return {15'd0, cfg_err};
            K_READY: return {15'd0, cfg_ready};
            K_PGOOD: return {15'd0, pwr_good};
            default: return {15'd0, sleep_ack};
        endcase
    endfunction

    task automatic push(input string nm, input int kind, input int ch, input logic [15:0] v);
        chk_t c;
        c.name = nm;
        c.kind = kind;
        c.ch   = ch;
        c.exp  = v;
        sb.push_back(c);
    endtask

    task automatic exp_cfg_all(input string nm, input logic [1:0] pb);
        for (int unsigned i = 0; i < N; i++) begin
            push(nm, K_CFG, int'(i), {sh[i][15:2], pb});
        end
    endtask

    task automatic exp_status(input string nm, input logic [2:0] st, input logic rdy,
                              input logic pg, input logic sa);
        push(nm, K_STATE, 0, {13'd0, st});
        push(nm, K_READY, 0, {15'd0, rdy});
        push(nm, K_PGOOD, 0, {15'd0, pg});
        push(nm, K_SACK, 0, {15'd0, sa});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every pending expectation against the settled outputs
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            chk_t        c;
            logic [15:0] a;
            c = sb.pop_front();
            a = actual(c.kind, c.ch);
            checks++;
            if (a !== c.exp) begin
                errors++;
                $display("FAIL %s kind%0d ch%0d: got %h expected %h", c.name, c.kind, c.ch, a, c.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        nreset = 1'b0; en = 1'b0; sleep_req = 1'b0; cfg_valid = 1'b0;
        cfg_bcast = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        for (int unsigned i = 0; i < N; i++) sh[i] = 16'hC000;

        // Reset state
        #2;
        exp_status("rst", 3'd0, 1'b1, 1'b0, 1'b0);
        push("rst_err", K_ERR, 0, 16'h0);
        exp_cfg_all("rst_cfg", 2'b00);
        step(); step();
        nreset = 1'b1;
        step();
        exp_status("off_idle", 3'd0, 1'b1, 1'b0, 1'b0);

        // Power-up: 1 edge to PWRUP, 4 in PWRUP, 2 in ARM
        en = 1'b1;
        step();
        exp_status("pwrup_entry", 3'd1, 1'b0, 1'b0, 1'b0);
        exp_cfg_all("pwrup_cfg", 2'b00);
        step(); step(); step();
        exp_status("pwrup_last", 3'd1, 1'b0, 1'b0, 1'b0);
        step();
        exp_status("arm_entry", 3'd2, 1'b0, 1'b0, 1'b0);
        exp_cfg_all("arm_cfg", 2'b10);
        step();
        exp_status("arm_last", 3'd2, 1'b0, 1'b0, 1'b0);
        step();
        exp_status("run", 3'd3, 1'b1, 1'b1, 1'b0);
        exp_cfg_all("run_cfg", 2'b11);

        // Addressed write in RUN
        cfg_valid = 1'b1; cfg_addr = 3'd2; cfg_wdata = 16'h0104;
        step();
        cfg_valid = 1'b0;
        sh[2] = 16'h0104;
        exp_cfg_all("wr_ch2", 2'b11);
        push("wr_ch2_err", K_ERR, 0, 16'h0);

        // Out-of-range writes
        cfg_valid = 1'b1; cfg_addr = 3'd5; cfg_wdata = 16'hFFFF;
        step();
        cfg_valid = 1'b0;
        push("err_addr5", K_ERR, 0, 16'h1);
        exp_cfg_all("err5_noupd", 2'b11);
        step();
        push("err5_end", K_ERR, 0, 16'h0);
        cfg_valid = 1'b1; cfg_addr = 3'd7; cfg_wdata = 16'hAAAA;
        step();
        cfg_valid = 1'b0;
        push("err_addr7", K_ERR, 0, 16'h1);
        step();
        push("err7_end", K_ERR, 0, 16'h0);
        exp_cfg_all("err7_noupd", 2'b11);

        // Write together with sleep_req in RUN
        sleep_req = 1'b1; cfg_valid = 1'b1; cfg_addr = 3'd3; cfg_wdata = 16'h1234;
        step();
        cfg_valid = 1'b0;
        sh[3] = 16'h1234;
        exp_status("hold", 3'd4, 1'b1, 1'b0, 1'b1);
        exp_cfg_all("hold_cfg", 2'b10);
        cfg_valid = 1'b1; cfg_addr = 3'd0; cfg_wdata = 16'h4000;
        step();
        cfg_valid = 1'b0;
        sh[0] = 16'h4000;
        exp_status("hold_wr", 3'd4, 1'b1, 1'b0, 1'b1);
        exp_cfg_all("hold_wr_cfg", 2'b10);

        // Release: two ARM cycles, writes refused while not ready
        sleep_req = 1'b0;
        step();
        exp_status("rel_arm", 3'd2, 1'b0, 1'b0, 1'b0);
        exp_cfg_all("rel_arm_cfg", 2'b10);
        cfg_valid = 1'b1; cfg_addr = 3'd1; cfg_wdata = 16'hFFFC;
        step();
        cfg_valid = 1'b0;
        exp_status("rel_arm2", 3'd2, 1'b0, 1'b0, 1'b0);
        exp_cfg_all("arm_nowr", 2'b10);
        step();
        exp_status("rel_run", 3'd3, 1'b1, 1'b1, 1'b0);
        exp_cfg_all("rel_run_cfg", 2'b11);

        // en drop with a write in the same cycle
        en = 1'b0; cfg_valid = 1'b1; cfg_addr = 3'd4; cfg_wdata = 16'h8888;
        step();
        cfg_valid = 1'b0;
        sh[4] = 16'h8888;
        exp_status("off_en", 3'd0, 1'b1, 1'b0, 1'b0);
        exp_cfg_all("off_en_cfg", 2'b00);

        // en drop mid-PWRUP
        en = 1'b1;
        step();
        push("re_pwrup", K_STATE, 0, 16'd1);
        step();
        en = 1'b0;
        step();
        exp_status("off_pwrup", 3'd0, 1'b1, 1'b0, 1'b0);
        exp_cfg_all("off_pwrup_cfg", 2'b00);

        // en drop mid-ARM
        en = 1'b1;
        step(); step(); step(); step(); step();
        push("re_arm", K_STATE, 0, 16'd2);
        en = 1'b0;
        step();
        exp_status("off_arm", 3'd0, 1'b1, 1'b0, 1'b0);
        exp_cfg_all("off_arm_cfg", 2'b00);

        // Restart must take the full count again
        en = 1'b1;
        step(); step(); step(); step();
        push("restart_pwrup_last", K_STATE, 0, 16'd1);
        step();
        push("restart_arm", K_STATE, 0, 16'd2);
        step(); step();
        exp_status("restart_run", 3'd3, 1'b1, 1'b1, 1'b0);
        exp_cfg_all("restart_run_cfg", 2'b11);

        // Broadcast write
        cfg_valid = 1'b1; cfg_bcast = 1'b1; cfg_addr = 3'd1; cfg_wdata = 16'h2000;
        step();
        cfg_valid = 1'b0; cfg_bcast = 1'b0;
`ifdef LA_IOBANK_BCAST_EN
        for (int unsigned i = 0; i < N; i++) sh[i] = 16'h2000;
`else
        sh[1] = 16'h2000;
`endif
        exp_cfg_all("bcast_cfg", 2'b11);
        push("bcast_err", K_ERR, 0, 16'h0);

        // Asynchronous reset in RUN
        @(posedge clk);
        #3;
        nreset = 1'b0;
        en = 1'b0;
        #1;
        for (int unsigned i = 0; i < N; i++) sh[i] = 16'hC000;
        exp_status("areset", 3'd0, 1'b1, 1'b0, 1'b0);
        exp_cfg_all("areset_cfg", 2'b00);
        push("areset_err", K_ERR, 0, 16'h0);
        step();
        nreset = 1'b1;
        step();
        exp_status("post_reset", 3'd0, 1'b1, 1'b0, 1'b0);
        exp_cfg_all("post_reset_cfg", 2'b00);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
